// File: rtl/pa_spsram_128x32_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pa_spsram_128x32_ctrl_if
// Brief    : Request/response channel between an LSU master and the
//            128x32 single-port SRAM access controller.
// Revision : 1.0 - initial release
// ============================================================================
interface pa_spsram_128x32_ctrl_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4
);
    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [BE_WIDTH-1:0]   req_be;
    logic                  resp_vld;
    logic                  resp_rdy;
    logic [DATA_WIDTH-1:0] resp_rdata;

    modport master (
        output req_vld, req_wr, req_addr, req_wdata, req_be, resp_rdy,
        input  req_rdy, resp_vld, resp_rdata
    );

    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, req_be, resp_rdy,
        output req_rdy, resp_vld, resp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/pa_spsram_128x32_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pa_spsram_128x32_ctrl
// Brief    : Valid/ready access controller for the LSU 128x32 single-port
//            SRAM. Optional post-reset zero-fill: PA_SPSRAM_CTRL_INIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pa_spsram_128x32_ctrl #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4
) (
    input  wire logic                  forever_cpuclk,
    input  wire logic                  cpurst,
    pa_spsram_128x32_ctrl_if.slave     bus,
    output logic                       init_done,
    output logic [ADDR_WIDTH-1:0]      sram_a,
    output logic                       sram_cen,
    output logic                       sram_gwen,
    output logic [DATA_WIDTH-1:0]      sram_wen,
    output logic [DATA_WIDTH-1:0]      sram_d,
    input  wire logic [DATA_WIDTH-1:0] sram_q
);

    logic                  w_init;
    logic [ADDR_WIDTH-1:0] w_init_addr;
    logic                  w_run;
    logic                  w_resp_pend;
    logic                  w_req_rdy;
    logic                  w_acc;
    logic [DATA_WIDTH-1:0] w_be_mask;

    logic                  r_rd_q_vld;
    logic                  r_hold_vld;
    logic [DATA_WIDTH-1:0] r_hold_data;

`ifdef PA_SPSRAM_CTRL_INIT_EN
    localparam logic [0:0] c_ST_INIT = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_init_cnt;

    // One zero-write per cycle; leave INIT after the last address is written.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_state    <= c_ST_INIT;
            r_init_cnt <= '0;
        end else if (r_state == c_ST_INIT) begin
            r_init_cnt <= r_init_cnt + 1'b1;
            if (r_init_cnt == {ADDR_WIDTH{1'b1}}) begin
                r_state <= c_ST_RUN;
            end
        end
    end

    assign w_init      = (r_state == c_ST_INIT);
    assign w_init_addr = r_init_cnt;
`else
    assign w_init      = 1'b0;
    assign w_init_addr = '0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < BE_WIDTH; gi++) begin : g_be_mask
            assign w_be_mask[8*gi +: 8] = {8{bus.req_be[gi]}};
        end
    endgenerate

    // Outputs are held at their reset values for as long as cpurst is high.
    assign w_run       = ~cpurst & ~w_init;
    assign w_resp_pend = r_rd_q_vld | r_hold_vld;
    assign w_req_rdy   = w_run & (~w_resp_pend | bus.resp_rdy);
    assign w_acc       = bus.req_vld & w_req_rdy;

    assign bus.req_rdy    = w_req_rdy;
    assign bus.resp_vld   = w_run & w_resp_pend;
    assign bus.resp_rdata = r_hold_vld ? r_hold_data : sram_q;
    assign init_done      = w_run;

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (w_init && !cpurst) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = w_init_addr;
        end else if (w_acc) begin
            sram_a = bus.req_addr;
            sram_d = bus.req_wdata;
            if (!bus.req_wr) begin
                sram_cen = 1'b0;
            end else if (|bus.req_be) begin
                // A fully masked write is accepted but never reaches the array.
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = ~w_be_mask;
            end
        end
    end

    // Q is only valid for one cycle, so capture it whenever it is not consumed.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_rd_q_vld  <= 1'b0;
            r_hold_vld  <= 1'b0;
            r_hold_data <= '0;
        end else begin
            r_rd_q_vld <= w_acc & ~bus.req_wr;
            if (r_rd_q_vld && !bus.resp_rdy) begin
                r_hold_vld  <= 1'b1;
                r_hold_data <= sram_q;
            end else if (bus.resp_rdy) begin
                r_hold_vld <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pa_spsram_128x32_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pa_spsram_128x32_ctrl
// Brief    : Vector-table bench for pa_spsram_128x32_ctrl with a behavioural
//            SRAM; zero-fill checks apply when PA_SPSRAM_CTRL_INIT_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pa_spsram_128x32_ctrl;

    localparam logic [31:0] c_ONES = 32'hFFFF_FFFF;

    typedef struct {
        logic        vld;
        logic        wr;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        rrdy;
        logic        e_rdy;
        logic        e_cen;
        logic        e_gwen;
        logic [31:0] e_wen;
        logic        e_rvld;
        logic [31:0] e_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic [6:0]  sram_a;
    logic        sram_cen;
    logic        sram_gwen;
    logic [31:0] sram_wen;
    logic [31:0] sram_d;
    logic [31:0] sram_q;
    logic [31:0] mem [128] = '{default: 32'hFFFF_FFFF};

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vt[$];

    always #5 clk = ~clk;

    pa_spsram_128x32_ctrl_if bus ();

    pa_spsram_128x32_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .bus            (bus),
        .init_done      (init_done),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    // Behavioural SRAM: Q is garbage except the cycle after a read.
    always @(posedge clk) begin
        if (!sram_cen && sram_gwen) begin
            sram_q <= mem[sram_a];
        end else begin
            sram_q <= $urandom;
        end
        if (!sram_cen && !sram_gwen) begin
            mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic vld, input logic wr, input logic [6:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be, input logic rrdy,
                                input logic e_rdy, input logic e_cen, input logic e_gwen,
                                input logic [31:0] e_wen, input logic e_rvld,
                                input logic [31:0] e_rdata);
        vec_t v;
        v.vld = vld; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be; v.rrdy = rrdy;
        v.e_rdy = e_rdy; v.e_cen = e_cen; v.e_gwen = e_gwen; v.e_wen = e_wen;
        v.e_rvld = e_rvld; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic drive(input logic vld, input logic wr, input logic [6:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input logic rrdy);
        bus.req_vld   = vld;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        bus.resp_rdy  = rrdy;
    endtask

    initial begin
        //          vld wr addr   wdata          be     rrdy  rdy cen gwen wen            rvld rdata
        vt.push_back(mk(1, 1, 7'h10, 32'hDEADBEEF, 4'hF, 1,   1, 0, 0, 32'h0000_0000, 0, 32'h0));
        vt.push_back(mk(1, 1, 7'h10, 32'h11223344, 4'h5, 1,   1, 0, 0, 32'hFF00_FF00, 0, 32'h0));
        vt.push_back(mk(1, 0, 7'h10, 32'h0,        4'h0, 1,   1, 0, 1, c_ONES,        0, 32'h0));
        vt.push_back(mk(1, 1, 7'h01, 32'h00000001, 4'hF, 1,   1, 0, 0, 32'h0000_0000, 1, 32'hDE22BE44));
        vt.push_back(mk(1, 1, 7'h02, 32'h00000002, 4'hF, 1,   1, 0, 0, 32'h0000_0000, 0, 32'h0));
        vt.push_back(mk(1, 1, 7'h03, 32'h00000003, 4'hF, 1,   1, 0, 0, 32'h0000_0000, 0, 32'h0));
        vt.push_back(mk(1, 1, 7'h04, 32'h00000004, 4'hF, 1,   1, 0, 0, 32'h0000_0000, 0, 32'h0));
        vt.push_back(mk(1, 1, 7'h05, 32'hA5A5A5A5, 4'hF, 1,   1, 0, 0, 32'h0000_0000, 0, 32'h0));
        vt.push_back(mk(1, 1, 7'h06, 32'h66666666, 4'hF, 1,   1, 0, 0, 32'h0000_0000, 0, 32'h0));
        // back-to-back reads
        vt.push_back(mk(1, 0, 7'h01, 32'h0,        4'h0, 1,   1, 0, 1, c_ONES,        0, 32'h0));
        vt.push_back(mk(1, 0, 7'h02, 32'h0,        4'h0, 1,   1, 0, 1, c_ONES,        1, 32'h1));
        vt.push_back(mk(1, 0, 7'h03, 32'h0,        4'h0, 1,   1, 0, 1, c_ONES,        1, 32'h2));
        vt.push_back(mk(1, 0, 7'h04, 32'h0,        4'h0, 1,   1, 0, 1, c_ONES,        1, 32'h3));
        vt.push_back(mk(0, 0, 7'h00, 32'h0,        4'h0, 1,   1, 1, 1, c_ONES,        1, 32'h4));
        vt.push_back(mk(0, 0, 7'h00, 32'h0,        4'h0, 1,   1, 1, 1, c_ONES,        0, 32'h0));
        // backpressure with response held
        vt.push_back(mk(1, 0, 7'h05, 32'h0,        4'h0, 1,   1, 0, 1, c_ONES,        0, 32'h0));
        vt.push_back(mk(1, 0, 7'h06, 32'h0,        4'h0, 0,   0, 1, 1, c_ONES,        1, 32'hA5A5A5A5));
        vt.push_back(mk(1, 0, 7'h06, 32'h0,        4'h0, 0,   0, 1, 1, c_ONES,        1, 32'hA5A5A5A5));
        vt.push_back(mk(1, 0, 7'h06, 32'h0,        4'h0, 0,   0, 1, 1, c_ONES,        1, 32'hA5A5A5A5));
        vt.push_back(mk(1, 0, 7'h06, 32'h0,        4'h0, 1,   1, 0, 1, c_ONES,        1, 32'hA5A5A5A5));
        vt.push_back(mk(0, 0, 7'h00, 32'h0,        4'h0, 1,   1, 1, 1, c_ONES,        1, 32'h66666666));
        // fully masked write then read back
        vt.push_back(mk(1, 1, 7'h05, 32'hFFFFFFFF, 4'h0, 1,   1, 1, 1, c_ONES,        0, 32'h0));
        vt.push_back(mk(1, 0, 7'h05, 32'h0,        4'h0, 1,   1, 0, 1, c_ONES,        0, 32'h0));
        vt.push_back(mk(0, 0, 7'h00, 32'h0,        4'h0, 1,   1, 1, 1, c_ONES,        1, 32'hA5A5A5A5));
        // read then write same address: old data
        vt.push_back(mk(1, 0, 7'h10, 32'h0,        4'h0, 1,   1, 0, 1, c_ONES,        0, 32'h0));
        vt.push_back(mk(1, 1, 7'h10, 32'h00000000, 4'hF, 1,   1, 0, 0, 32'h0000_0000, 1, 32'hDE22BE44));
        vt.push_back(mk(0, 0, 7'h00, 32'h0,        4'h0, 1,   1, 1, 1, c_ONES,        0, 32'h0));
        vt.push_back(mk(1, 0, 7'h10, 32'h0,        4'h0, 1,   1, 0, 1, c_ONES,        0, 32'h0));
        vt.push_back(mk(0, 0, 7'h00, 32'h0,        4'h0, 1,   1, 1, 1, c_ONES,        1, 32'h0));
        // write then read same address: new data
        vt.push_back(mk(1, 1, 7'h20, 32'hCAFEF00D, 4'hF, 1,   1, 0, 0, 32'h0000_0000, 0, 32'h0));
        vt.push_back(mk(1, 0, 7'h20, 32'h0,        4'h0, 1,   1, 0, 1, c_ONES,        0, 32'h0));
        vt.push_back(mk(0, 0, 7'h00, 32'h0,        4'h0, 1,   1, 1, 1, c_ONES,        1, 32'hCAFEF00D));

        // reset state
        rst = 1'b1;
        drive(0, 0, 7'h00, 32'h0, 4'h0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("reset ctl {resp_vld,init_done,req_rdy,cen,gwen}",
            {bus.resp_vld, init_done, bus.req_rdy, sram_cen, sram_gwen}, 5'b00011);
        chk("reset wen/d", {sram_wen, sram_d}, {c_ONES, 32'h0});
        chk("reset a", sram_a, 7'h00);

        @(negedge clk);
        rst = 1'b0;
`ifdef PA_SPSRAM_CTRL_INIT_EN
        drive(1, 0, 7'h55, 32'h0, 4'h0, 1);
        for (int k = 0; k < 128; k++) begin
            #1;
            chk($sformatf("init cyc%0d {a,cen,gwen,rdy,done}", k),
                {sram_a, sram_cen, sram_gwen, bus.req_rdy, init_done}, {k[6:0], 4'b0000});
            chk($sformatf("init cyc%0d wen/d", k), {sram_wen, sram_d}, 64'h0);
            @(negedge clk);
        end
        #1;
        chk("init_done on cycle 129", {init_done, bus.req_rdy, sram_cen, sram_a}, {3'b110, 7'h55});
        @(negedge clk);
        drive(0, 0, 7'h00, 32'h0, 4'h0, 1);
        #1;
        chk("read 0x55 after zero-fill", {bus.resp_vld, bus.resp_rdata}, {1'b1, 32'h0});
`else
        #1;
        chk("first run cycle {init_done,req_rdy,cen}", {init_done, bus.req_rdy, sram_cen}, 3'b111);
`endif

        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].vld, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].be, vt[i].rrdy);
            #1;
            chk($sformatf("row%0d req_rdy", i), bus.req_rdy, vt[i].e_rdy);
            chk($sformatf("row%0d cen", i), sram_cen, vt[i].e_cen);
            chk($sformatf("row%0d resp_vld", i), bus.resp_vld, vt[i].e_rvld);
            if (vt[i].e_rvld) chk($sformatf("row%0d rdata", i), bus.resp_rdata, vt[i].e_rdata);
            if (!vt[i].e_cen) begin
                chk($sformatf("row%0d a/gwen/wen", i), {sram_a, sram_gwen, sram_wen},
                    {vt[i].addr, vt[i].e_gwen, vt[i].e_wen});
                if (!vt[i].e_gwen) chk($sformatf("row%0d d", i), sram_d, vt[i].wdata);
            end
        end

        // reset while a response is held
        @(negedge clk);
        drive(1, 0, 7'h05, 32'h0, 4'h0, 1);
        @(negedge clk);
        drive(0, 0, 7'h00, 32'h0, 4'h0, 0);
        @(negedge clk);
        #1;
        chk("held before reset", {bus.resp_vld, bus.resp_rdata}, {1'b1, 32'hA5A5A5A5});
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset drops resp_vld", {bus.resp_vld, bus.req_rdy, sram_cen}, 3'b001);
        @(negedge clk);
        rst = 1'b0;
        #1;
`ifdef PA_SPSRAM_CTRL_INIT_EN
        chk("post-reset INIT restart", {bus.resp_vld, init_done, sram_cen, sram_a}, {3'b000, 7'h00});
        repeat (40) @(negedge clk);
        #1;
        chk("init at cnt 40", {sram_cen, sram_a}, {1'b0, 7'd40});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("INIT restarts at 0", {init_done, sram_cen, sram_a}, {2'b00, 7'h00});
`else
        chk("post-reset held response gone", {bus.resp_vld, bus.req_rdy, init_done}, 3'b011);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pa_spsram_128x32_ctrl.md
Name: pa_spsram_128x32_ctrl

Overview:
Request/response access controller directly upstream of the LSU 128x32 single-port SRAM wrapper. Converts a valid/ready request channel (read or byte-masked write) into the SRAM's active-low CEN/GWEN/bit-WEN pins. Captures the SRAM's one-cycle-late Q into a held response with backpressure. Optionally zero-fills the array after reset.

Parameters:
ADDR_WIDTH, 7, SRAM word address width (128 entries)
DATA_WIDTH, 32, SRAM data width
BE_WIDTH, 4, byte-enable width (DATA_WIDTH/8)

Ports:
forever_cpuclk  input  1  clock, shared with SRAM CLK
cpurst  input  1  synchronous active-high reset
req_vld  input  1  request valid
req_rdy  output  1  request ready
req_wr  input  1  1 = write, 0 = read
req_addr  input  7  word address
req_wdata  input  32  write data
req_be  input  4  byte enables, bit i covers data[8i+7:8i]
resp_vld  output  1  read response valid
resp_rdy  input  1  read response accepted
resp_rdata  output  32  read data
init_done  output  1  array ready for requests
sram_a  output  7  to SRAM A
sram_cen  output  1  to SRAM CEN, active low
sram_gwen  output  1  to SRAM GWEN, 0 = write
sram_wen  output  32  to SRAM WEN, per-bit active low
sram_d  output  32  to SRAM D
sram_q  input  32  from SRAM Q, valid the cycle after a read

Behaviour:
- Clocking and reset: one clock, forever_cpuclk. cpurst is synchronous and active-high. All state is updated on the rising edge.
- Reset values:
  - resp_vld=0, init_done=0, req_rdy=0.
  - sram_cen=1, sram_gwen=1, sram_wen=all 1s, sram_a=0, sram_d=0.
  - rd_q_vld=0, hold_vld=0, init_cnt=0.
- States: INIT (feature only) and RUN. Reset enters INIT when the feature is compiled in, otherwise RUN. Reset asserted in any state returns there with init_cnt=0. Any pending or held response is discarded.
- RUN handshake:
  - resp_vld = rd_q_vld | hold_vld.
  - req_rdy = ~resp_vld | resp_rdy.
  - init_done=1 throughout RUN.
- Request accepted when req_vld & req_rdy. SRAM pins are driven combinationally in that same cycle:
  - sram_cen=0, sram_a=req_addr, sram_d=req_wdata.
  - Read: sram_gwen=1, sram_wen=all 1s, rd_q_vld<=1.
  - Write: sram_gwen=0, sram_wen[8i+7:8i]=~{8{req_be[i]}}, rd_q_vld<=0.
  - Write with req_be=0: accepted, no SRAM access (sram_cen=1).
- No accepted request: sram_cen=1, sram_gwen=1, sram_wen=all 1s, rd_q_vld<=0.
- Read latency: request accepted in cycle N; resp_vld=1 and resp_rdata=sram_q in cycle N+1.
- Response hold:
  - If rd_q_vld & ~resp_rdy: hold_data<=sram_q, hold_vld<=1.
  - While hold_vld=1, resp_rdata=hold_data.
  - hold_vld clears on the cycle resp_rdy=1.
  - Held data stays stable until accepted.
- Throughput:
  - Back-to-back reads at 1 per cycle when resp_rdy is held at 1.
  - Any resp_rdy=0 with a response valid stalls new requests, because req_rdy=0.
- Ordering: a write accepted in cycle N followed by a read of the same address in N+1 returns the new data. A read in N and a write in N+1 return the old data.
- Writes generate no response.

Optional Feature:
PA_SPSRAM_CTRL_INIT_EN
- With the macro: after reset, INIT runs for 128 cycles.
  - Each cycle: sram_cen=0, sram_gwen=0, sram_wen=0, sram_d=0, sram_a=init_cnt; init_cnt increments.
  - req_rdy=0 and init_done=0 throughout INIT.
  - After the cycle with init_cnt=127, the next state is RUN, so init_done=1 on the 129th cycle after reset deasserts.
- Without the macro: no INIT state and no init_cnt. RUN begins on the first cycle after reset deasserts, with init_done=1. Array contents are undefined until written.

Test Plan:
- INIT_EN build: deassert reset -> 128 consecutive zero-writes to addresses 0..127; init_done rises on cycle 129; reading addr 0x55 returns 0x00000000.
- Write addr 0x10 data 0xDEADBEEF be=4'b1111; then write addr 0x10 data 0x11223344 be=4'b0101; read addr 0x10 -> resp_rdata=0xDE22BE44 one cycle after acceptance.
- Read addrs 1,2,3,4 back-to-back with resp_rdy=1 -> req_rdy stays 1, resp_vld high 4 consecutive cycles, data in order.
- Read addr 5 (holding 0xA5A5A5A5), resp_rdy=0 for 3 cycles while req_vld=1 -> req_rdy=0, sram_cen=1, resp_rdata stable 0xA5A5A5A5; resp_rdy=1 -> accepted, next request issues in the same cycle.
- Write with be=4'b0000 -> req_rdy=1, sram_cen stays 1, subsequent read shows data unchanged.
- Assert cpurst during INIT at init_cnt=40 and with a held response in RUN -> resp_vld=0 next cycle; INIT restarts at address 0.
